// File: rtl/v_issue_pkg.sv
// Shared constants, FSM state type and issue-field bundle for the vector issue controller.
package v_issue_pkg;

   localparam logic [6:0] OpV   = 7'b1010111;
   localparam logic [6:0] OpVld = 7'b0000111;
   localparam logic [6:0] OpVst = 7'b0100111;

   localparam logic [2:0] F3Opivv = 3'b000;
   localparam logic [2:0] F3Opmvv = 3'b010;
   localparam logic [2:0] F3Opivi = 3'b011;
   localparam logic [2:0] F3Opivx = 3'b100;
   localparam logic [2:0] F3Opmvx = 3'b110;
   localparam logic [2:0] F3Opcfg = 3'b111;

   localparam logic [5:0] F6Slideup   = 6'b001110;
   localparam logic [5:0] F6Slidedown = 6'b001111;
   localparam logic [5:0] F6Rgather   = 6'b001100;
   localparam logic [5:0] F6Wxunary0  = 6'b010000;

   localparam logic [1:0] PermNone   = 2'b00;
   localparam logic [1:0] PermUp     = 2'b01;
   localparam logic [1:0] PermDown   = 2'b10;
   localparam logic [1:0] PermGather = 2'b11;

   localparam logic [1:0] AluVv = 2'b00;
   localparam logic [1:0] AluVx = 2'b01;
   localparam logic [1:0] AluVi = 2'b10;

   localparam int unsigned VlW = 9;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   typedef struct packed {
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [4:0] uimm5;
      logic [7:0] funct;
      logic [1:0] permute;
      logic       mask_en;
      logic [1:0] alu_src;
      logic       dmr;
      logic       dmw;
      logic       reg_we;
      logic       mem_reg;
      logic       xout;
      logic [1:0] mode_lsu;
   } issue_t;

   function automatic logic [1:0] permute_sel(input logic [5:0] funct6);
      case (funct6)
         F6Slideup:   return PermUp;
         F6Slidedown: return PermDown;
         F6Rgather:   return PermGather;
         default:     return PermNone;
      endcase
   endfunction

endpackage

// File: rtl/v_issue_ctrl_if.sv
// Issue bus to the vector unit plus its handshake and scalar writeback request.
interface v_issue_ctrl_if;
   logic        start;
   logic [4:0]  vs1;
   logic [4:0]  vs2;
   logic [4:0]  vd;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  uimm5;
   logic [7:0]  funct;
   logic [1:0]  permute;
   logic        mask_en;
   logic [1:0]  alu_src;
   logic        dmr;
   logic        dmw;
   logic        reg_we;
   logic        mem_reg;
   logic        xout;
   logic [1:0]  mode_lsu;
   logic [2:0]  id;
   logic        clear;
   logic        stall;
   logic        done;
   logic [4:0]  xrf_addr;
   logic [31:0] xrf_data;
   logic        xrf_we;

   modport master (
      output start, vs1, vs2, vd, rs1, rs2, uimm5, funct, permute, mask_en, alu_src,
             dmr, dmw, reg_we, mem_reg, xout, mode_lsu, id, clear,
      input  stall, done, xrf_addr, xrf_data, xrf_we
   );

   modport slave (
      input  start, vs1, vs2, vd, rs1, rs2, uimm5, funct, permute, mask_en, alu_src,
             dmr, dmw, reg_we, mem_reg, xout, mode_lsu, id, clear,
      output stall, done, xrf_addr, xrf_data, xrf_we
   );
endinterface

// File: rtl/v_instr_decode.sv
// Combinational RVV decoder: instruction word to issue fields plus legal / vsetvli flags.
module v_instr_decode
   import v_issue_pkg::*;
(
   input  logic [31:0] i_instr,
   output issue_t      o_fields,
   output logic        o_legal,
   output logic        o_is_cfg
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [5:0] w_f6;
   logic [4:0] w_vs1;
   logic       w_to_scalar;

   assign w_opc = i_instr[6:0];
   assign w_f3  = i_instr[14:12];
   assign w_f6  = i_instr[31:26];
   assign w_vs1 = i_instr[19:15];

   // VWXUNARY0 encodings that write a scalar: vmv.x.s, vcpop.m, vfirst.m
   assign w_to_scalar = (w_f3 == F3Opmvv) && (w_f6 == F6Wxunary0) &&
                        ((w_vs1 == 5'd0) || (w_vs1 == 5'd16) || (w_vs1 == 5'd17));

   always_comb begin
      o_fields         = '0;
      o_legal          = 1'b0;
      o_is_cfg         = 1'b0;
      o_fields.vd      = i_instr[11:7];
      o_fields.vs1     = w_vs1;
      o_fields.uimm5   = w_vs1;
      o_fields.vs2     = i_instr[24:20];
      o_fields.mask_en = ~i_instr[25];
      o_fields.funct   = {w_f6, w_f3[1:0]};
      case (w_opc)
         OpV: begin
            o_is_cfg         = (w_f3 == F3Opcfg);
            o_fields.permute = permute_sel(w_f6);
            o_fields.xout    = w_to_scalar;
            o_fields.reg_we  = ~w_to_scalar;
            case (w_f3)
               F3Opivv, F3Opmvv: begin
                  o_legal          = 1'b1;
                  o_fields.alu_src = AluVv;
               end
               F3Opivx, F3Opmvx: begin
                  o_legal          = 1'b1;
                  o_fields.alu_src = AluVx;
               end
               F3Opivi: begin
                  o_legal          = 1'b1;
                  o_fields.alu_src = AluVi;
               end
               default: o_legal = 1'b0;
            endcase
         end
         OpVld: begin
            o_legal           = 1'b1;
            o_fields.dmr      = 1'b1;
            o_fields.reg_we   = 1'b1;
            o_fields.mem_reg  = 1'b1;
            o_fields.mode_lsu = i_instr[27:26];
         end
         OpVst: begin
            o_legal           = 1'b1;
            o_fields.dmw      = 1'b1;
            o_fields.mode_lsu = i_instr[27:26];
         end
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/v_issue_ctrl.sv
// Scalar-side vector issue controller: runs vsetvli locally, issues other vector ops,
// waits for completion under a watchdog and muxes scalar register-file writeback.
module v_issue_ctrl
   import v_issue_pkg::*;
#(
   parameter int unsigned MaxVl    = 256,
   parameter int unsigned ToCycles = 4096
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_instr_valid,
   input  logic [31:0]    i_instr,
   input  logic [31:0]    i_rs1_val,
   input  logic [31:0]    i_rs2_val,
   output logic           o_instr_ready,
   output logic           o_busy,
   output logic           o_err,
   output logic [VlW-1:0] o_vl,
   v_issue_ctrl_if.master vif,
   output logic [4:0]     o_xrf_wb_addr,
   output logic [31:0]    o_xrf_wb_data,
   output logic           o_xrf_wb_we
);

   localparam int unsigned WdogW = (ToCycles > 1) ? $clog2(ToCycles) : 1;

   state_e           r_state, w_state_d;
   issue_t           r_iss, w_dec;
   logic             w_legal, w_is_cfg;
   logic [31:0]      r_rs1, r_rs2;
   logic [2:0]       r_id;
   logic             r_clear, r_err;
   logic [VlW-1:0]   r_vl, w_vl_d;
   logic             r_cfg_we;
   logic [4:0]       r_cfg_addr;
   logic [WdogW-1:0] r_wdog;
   logic             w_accept, w_cfg, w_illegal, w_fire, w_abort, w_collide;

   v_instr_decode u_decode (
      .i_instr  (i_instr),
      .o_fields (w_dec),
      .o_legal  (w_legal),
      .o_is_cfg (w_is_cfg)
   );

   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      w_cfg     = 1'b0;
      w_illegal = 1'b0;
      w_fire    = 1'b0;
      w_abort   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_instr_valid) begin
               if (w_is_cfg) begin
                  w_cfg = 1'b1;
               end else if (w_legal) begin
                  w_accept  = 1'b1;
                  w_state_d = StIssue;
               end else begin
                  w_illegal = 1'b1;
               end
            end
         end
         StIssue: begin
            if (!vif.stall) begin
               w_fire    = 1'b1;
               w_state_d = StWait;
            end
         end
         StWait: begin
            if (vif.done) begin
               w_state_d = StIdle;
            end else if (r_wdog == WdogW'(ToCycles - 1)) begin
               w_abort   = 1'b1;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // rs1=x0 with rd!=x0 requests VLMAX; rs1=x0 with rd=x0 keeps the current vl
   always_comb begin
      w_vl_d = r_vl;
      if (w_cfg) begin
         if (w_dec.vs1 == 5'd0) begin
            if (w_dec.vd != 5'd0) w_vl_d = VlW'(MaxVl);
         end else if (i_rs1_val > MaxVl) begin
            w_vl_d = VlW'(MaxVl);
         end else begin
            w_vl_d = i_rs1_val[VlW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_iss      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_id       <= '0;
         r_clear    <= 1'b0;
         r_err      <= 1'b0;
         r_vl       <= '0;
         r_cfg_we   <= 1'b0;
         r_cfg_addr <= '0;
         r_wdog     <= '0;
      end else begin
         r_state    <= w_state_d;
         r_vl       <= w_vl_d;
         r_cfg_we   <= w_cfg && (w_dec.vd != 5'd0);
         r_cfg_addr <= w_dec.vd;
         r_err      <= w_illegal | w_abort;
         r_clear    <= w_abort;
         if (w_accept) begin
            r_iss <= w_dec;
            r_rs1 <= i_rs1_val;
            r_rs2 <= i_rs2_val;
         end
         if (w_fire) begin
            r_id   <= r_id + 3'd1;
            r_wdog <= '0;
         end else if (r_state == StWait) begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign vif.start    = (r_state == StIssue);
   assign vif.vs1      = r_iss.vs1;
   assign vif.vs2      = r_iss.vs2;
   assign vif.vd       = r_iss.vd;
   assign vif.rs1      = r_rs1;
   assign vif.rs2      = r_rs2;
   assign vif.uimm5    = r_iss.uimm5;
   assign vif.funct    = r_iss.funct;
   assign vif.permute  = r_iss.permute;
   assign vif.mask_en  = r_iss.mask_en;
   assign vif.alu_src  = r_iss.alu_src;
   assign vif.dmr      = r_iss.dmr;
   assign vif.dmw      = r_iss.dmw;
   assign vif.reg_we   = r_iss.reg_we;
   assign vif.mem_reg  = r_iss.mem_reg;
   assign vif.xout     = r_iss.xout;
   assign vif.mode_lsu = r_iss.mode_lsu;
   assign vif.id       = r_id;
   assign vif.clear    = r_clear;

   assign o_instr_ready = (r_state == StIdle);
   assign o_busy        = i_instr_valid & ~o_instr_ready;
   assign o_vl          = r_vl;

   // Vector-unit writes take priority; a clashing vsetvli write is dropped and flagged
   assign w_collide = vif.xrf_we & r_cfg_we;
   assign o_err     = r_err | w_collide;

   always_comb begin
      o_xrf_wb_we   = 1'b0;
      o_xrf_wb_addr = '0;
      o_xrf_wb_data = '0;
      if (vif.xrf_we) begin
         o_xrf_wb_we   = 1'b1;
         o_xrf_wb_addr = vif.xrf_addr;
         o_xrf_wb_data = vif.xrf_data;
      end else if (r_cfg_we) begin
         o_xrf_wb_we   = 1'b1;
         o_xrf_wb_addr = r_cfg_addr;
         o_xrf_wb_data = {{(32 - VlW){1'b0}}, r_vl};
      end
   end

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Self-checking bench for v_issue_ctrl: directed scenarios plus randomized ops against a model.
module tb_v_issue_ctrl;

   localparam int unsigned MaxVl    = 256;
   localparam int unsigned ToCycles = 4096;

   typedef struct packed {
      logic [31:0] ins;
      logic [4:0]  vd;
      logic [4:0]  vs1;
      logic [4:0]  vs2;
      logic [7:0]  funct;
      logic [1:0]  perm;
      logic [1:0]  alu;
      logic [1:0]  mode;
      logic        mask_en;
      logic        dmr;
      logic        dmw;
      logic        reg_we;
      logic        mem_reg;
      logic        xout;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_instr_valid;
   logic [31:0] i_instr, i_rs1_val, i_rs2_val;
   logic        o_instr_ready, o_busy, o_err;
   logic [8:0]  o_vl;
   logic [4:0]  o_xrf_wb_addr;
   logic [31:0] o_xrf_wb_data;
   logic        o_xrf_wb_we;

   int n_vec = 0;
   int n_err = 0;
   int m_vl  = 0;
   int m_id  = 0;

   v_issue_ctrl_if vif ();

   v_issue_ctrl #(
      .MaxVl    (MaxVl),
      .ToCycles (ToCycles)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_instr_valid (i_instr_valid),
      .i_instr       (i_instr),
      .i_rs1_val     (i_rs1_val),
      .i_rs2_val     (i_rs2_val),
      .o_instr_ready (o_instr_ready),
      .o_busy        (o_busy),
      .o_err         (o_err),
      .o_vl          (o_vl),
      .vif           (vif),
      .o_xrf_wb_addr (o_xrf_wb_addr),
      .o_xrf_wb_data (o_xrf_wb_data),
      .o_xrf_wb_we   (o_xrf_wb_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected issue fields follow from the chosen instruction class, not from the bit pattern
   function automatic op_t mk_op(input int kind, input logic [5:0] f6, input logic vm,
                                 input logic [4:0] vd, input logic [4:0] vs1,
                                 input logic [4:0] vs2, input logic [2:0] width);
      op_t o;
      logic [2:0] f3;
      logic [6:0] opc;
      o = '0;
      o.vd = vd;
      o.vs1 = vs1;
      o.vs2 = vs2;
      o.mask_en = !vm;
      opc = 7'h57;
      case (kind)
         0: f3 = 3'd0;
         1: f3 = 3'd2;
         2: f3 = 3'd4;
         3: f3 = 3'd6;
         4: f3 = 3'd3;
         5: begin f3 = width; opc = 7'h07; end
         default: begin f3 = width; opc = 7'h27; end
      endcase
      o.funct = 8'(int'(f6) * 4 + int'(f3) % 4);
      if (kind <= 4) begin
         o.alu  = (kind <= 1) ? 2'd0 : (kind <= 3) ? 2'd1 : 2'd2;
         o.perm = (f6 == 6'd14) ? 2'd1 : (f6 == 6'd15) ? 2'd2 : (f6 == 6'd12) ? 2'd3 : 2'd0;
         o.xout = (kind == 1) && (f6 == 6'd16) && (vs1 == 5'd0 || vs1 == 5'd16 || vs1 == 5'd17);
         o.reg_we = !o.xout;
      end else if (kind == 5) begin
         o.dmr = 1'b1;
         o.reg_we = 1'b1;
         o.mem_reg = 1'b1;
         o.mode = f6[1:0];
      end else begin
         o.dmw = 1'b1;
         o.mode = f6[1:0];
      end
      o.ins = {f6, vm, vs2, vs1, f3, vd, opc};
      return o;
   endfunction

   function automatic op_t rand_op();
      int kind;
      logic [5:0] f6;
      logic [4:0] vs1;
      logic [2:0] w;
      kind = $urandom_range(0, 6);
      case ($urandom_range(0, 5))
         0: f6 = 6'b001110;
         1: f6 = 6'b001111;
         2: f6 = 6'b001100;
         3: f6 = 6'b010000;
         4: f6 = 6'b000000;
         default: f6 = 6'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: vs1 = 5'd0;
         1: vs1 = 5'd16;
         2: vs1 = 5'd17;
         default: vs1 = 5'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: w = 3'b000;
         1: w = 3'b101;
         2: w = 3'b110;
         default: w = 3'b111;
      endcase
      return mk_op(kind, f6, 1'($urandom), 5'($urandom), vs1, 5'($urandom), w);
   endfunction

   task automatic chk_fields(input op_t o, input logic [31:0] a, input logic [31:0] b);
      chk("vd", vif.vd, o.vd);
      chk("vs1", vif.vs1, o.vs1);
      chk("vs2", vif.vs2, o.vs2);
      chk("uimm5", vif.uimm5, o.vs1);
      chk("funct", vif.funct, o.funct);
      chk("permute", vif.permute, o.perm);
      chk("alusrc", vif.alu_src, o.alu);
      chk("mask_en", vif.mask_en, o.mask_en);
      chk("dmr", vif.dmr, o.dmr);
      chk("dmw", vif.dmw, o.dmw);
      chk("reg_we", vif.reg_we, o.reg_we);
      chk("mem_reg", vif.mem_reg, o.mem_reg);
      chk("xout", vif.xout, o.xout);
      chk("mode_lsu", vif.mode_lsu, o.mode);
      chk("rs1", vif.rs1, a);
      chk("rs2", vif.rs2, b);
   endtask

   task automatic do_cfg(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] val,
                         input bit collide);
      logic [10:0] zimm;
      zimm = 11'($urandom);
      i_instr_valid = 1'b1;
      i_instr = {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
      i_rs1_val = val;
      i_rs2_val = $urandom;
      #1;
      chk("cfg_ready", o_instr_ready, 1);
      chk("cfg_busy", o_busy, 0);
      if (rs1 == 5'd0) begin
         if (rd != 5'd0) m_vl = MaxVl;
      end else begin
         m_vl = (val > MaxVl) ? MaxVl : int'(val);
      end
      @(negedge clk);
      i_instr_valid = 1'b0;
      if (collide) begin
         vif.xrf_we = 1'b1;
         vif.xrf_addr = 5'd7;
         vif.xrf_data = 32'hDEAD;
      end
      #1;
      chk("cfg_vl", o_vl, 64'(m_vl));
      chk("cfg_stay_idle", o_instr_ready, 1);
      chk("cfg_start", vif.start, 0);
      chk("cfg_err", o_err, collide && (rd != 5'd0));
      if (collide) begin
         chk("wb_vu_addr", o_xrf_wb_addr, 7);
         chk("wb_vu_data", o_xrf_wb_data, 32'hDEAD);
         chk("wb_vu_we", o_xrf_wb_we, 1);
      end else begin
         chk("cfg_wb_we", o_xrf_wb_we, rd != 5'd0);
         if (rd != 5'd0) begin
            chk("cfg_wb_addr", o_xrf_wb_addr, rd);
            chk("cfg_wb_data", o_xrf_wb_data, 64'(m_vl));
         end
      end
      @(negedge clk);
      vif.xrf_we = 1'b0;
      vif.xrf_addr = '0;
      vif.xrf_data = '0;
      #1;
      chk("cfg_wb_off", o_xrf_wb_we, 0);
      chk("cfg_err_off", o_err, 0);
   endtask

   task automatic run_op(input op_t o, input int stall_n, input int done_dly);
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      i_instr_valid = 1'b1;
      i_instr = o.ins;
      i_rs1_val = a;
      i_rs2_val = b;
      #1;
      chk("op_ready", o_instr_ready, 1);
      chk("op_start_pre", vif.start, 0);
      @(negedge clk);
      i_instr_valid = 1'b0;
      i_instr = $urandom;
      i_rs1_val = $urandom;
      i_rs2_val = $urandom;
      for (int k = 0; k <= stall_n; k++) begin
         vif.stall = (k < stall_n);
         vif.done = 1'($urandom);
         #1;
         chk("issue_start", vif.start, 1);
         chk("issue_ready", o_instr_ready, 0);
         chk("issue_id", vif.id, 64'(m_id));
         if (k == 0 || k == stall_n) chk_fields(o, a, b);
         @(negedge clk);
      end
      vif.stall = 1'b0;
      m_id = (m_id + 1) % 8;
      for (int j = 0; j <= done_dly; j++) begin
         i_instr_valid = 1'($urandom);
         vif.done = (j == done_dly);
         #1;
         chk("wait_start", vif.start, 0);
         chk("wait_ready", o_instr_ready, 0);
         chk("wait_busy", o_busy, i_instr_valid);
         chk("wait_id", vif.id, 64'(m_id));
         chk("wait_err", o_err, 0);
         @(negedge clk);
      end
      vif.done = 1'b0;
      i_instr_valid = 1'b0;
      #1;
      chk("op_back_idle", o_instr_ready, 1);
   endtask

   task automatic do_illegal(input logic [31:0] ins);
      i_instr_valid = 1'b1;
      i_instr = ins;
      #1;
      chk("ill_ready", o_instr_ready, 1);
      @(negedge clk);
      i_instr_valid = 1'b0;
      #1;
      chk("ill_err", o_err, 1);
      chk("ill_start", vif.start, 0);
      chk("ill_ready_after", o_instr_ready, 1);
      @(negedge clk);
      #1;
      chk("ill_err_off", o_err, 0);
      chk("ill_start_off", vif.start, 0);
   endtask

   task automatic run_timeout(input op_t o);
      int n;
      i_instr_valid = 1'b1;
      i_instr = o.ins;
      @(negedge clk);
      i_instr_valid = 1'b0;
      vif.stall = 1'b0;
      vif.done = 1'b0;
      #1;
      chk("wd_start", vif.start, 1);
      @(negedge clk);
      m_id = (m_id + 1) % 8;
      n = 0;
      #1;
      while (vif.clear !== 1'b1 && n <= ToCycles + 20) begin
         if (n == ToCycles / 2) chk("wd_mid_wait", o_instr_ready, 0);
         @(negedge clk);
         #1;
         n++;
      end
      chk("wd_cycles", n, ToCycles);
      chk("wd_clear", vif.clear, 1);
      chk("wd_err", o_err, 1);
      chk("wd_idle", o_instr_ready, 1);
      @(negedge clk);
      #1;
      chk("wd_clear_off", vif.clear, 0);
      chk("wd_err_off", o_err, 0);
   endtask

   initial begin
      op_t o;
      logic [31:0] w;
      int r;
      rst_n = 1'b0;
      i_instr_valid = 1'b0;
      i_instr = '0;
      i_rs1_val = '0;
      i_rs2_val = '0;
      vif.stall = 1'b0;
      vif.done = 1'b0;
      vif.xrf_we = 1'b0;
      vif.xrf_addr = '0;
      vif.xrf_data = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_vl", o_vl, 0);
      chk("rst_id", vif.id, 0);
      chk("rst_start", vif.start, 0);
      chk("rst_err", o_err, 0);
      chk("rst_clear", vif.clear, 0);
      chk("rst_wb_we", o_xrf_wb_we, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_idle", o_instr_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      do_cfg(5'd5, 5'd6, 32'd300, 1'b0);
      do_cfg(5'd5, 5'd6, 32'd17, 1'b0);
      run_op(mk_op(0, 6'd0, 1'b1, 5'd3, 5'd1, 5'd2, 3'd0), 0, 4);
      run_op(mk_op(4, 6'd0, 1'b1, 5'd9, 5'd21, 5'd8, 3'd0), 4, 2);
      run_op(mk_op(1, 6'b010000, 1'b1, 5'd7, 5'd0, 5'd4, 3'd0), 0, 1);

      vif.xrf_we = 1'b1;
      vif.xrf_addr = 5'd7;
      vif.xrf_data = 32'hDEAD;
      #1;
      chk("xrf_addr", o_xrf_wb_addr, 7);
      chk("xrf_data", o_xrf_wb_data, 32'hDEAD);
      chk("xrf_we", o_xrf_wb_we, 1);
      chk("xrf_err", o_err, 0);
      vif.xrf_addr = 5'd0;
      vif.xrf_data = 32'h1234_5678;
      #1;
      chk("xrf_x0_addr", o_xrf_wb_addr, 0);
      chk("xrf_x0_data", o_xrf_wb_data, 32'h1234_5678);
      vif.xrf_we = 1'b0;
      @(negedge clk);

      do_cfg(5'd9, 5'd6, 32'd40, 1'b1);

      o = rand_op();
      i_instr_valid = 1'b1;
      i_instr = o.ins;
      @(negedge clk);
      i_instr_valid = 1'b0;
      vif.stall = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_pre_wait", o_instr_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_vl", o_vl, 0);
      chk("arst_id", vif.id, 0);
      chk("arst_start", vif.start, 0);
      chk("arst_vd", vif.vd, 0);
      chk("arst_funct", vif.funct, 0);
      chk("arst_clear", vif.clear, 0);
      chk("arst_err", o_err, 0);
      chk("arst_idle", o_instr_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      m_vl = 0;
      m_id = 0;

      for (int i = 0; i < 9; i++) run_op(rand_op(), 0, 0);
      do_illegal(32'h0000_0013);

      run_timeout(rand_op());

      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            do_cfg(5'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 400)) : $urandom,
                   $urandom_range(0, 4) == 0);
         end else if (r == 2) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               w[6:0] = 7'h13;
            end else begin
               w[6:0] = 7'h57;
               w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
            end
            do_illegal(w);
         end else begin
            run_op(rand_op(), $urandom_range(0, 3), $urandom_range(0, 5));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1, "bench time limit reached");
   end

endmodule
